univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/shreg_pkg.sv | 18 +
 rtl/shreg_cnt.sv | 35 +++
 rtl/univ_shift_reg.sv | 151 +++++++++++++++
 tb/tb_univ_shift_reg.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// shreg_pkg -- shared definitions for the universal shift register.
//   mode_e  : command encodings carried on the 2-bit mode input
//   state_e : control FSM state encodings
package shreg_pkg;

    typedef enum logic [1:0] {
        MODE_NOP  = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/shreg_cnt.sv
// shreg_cnt -- loadable down-counter with zero flag; terminates a shift burst.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one (saturates at zero)
//   zero      : count is zero
module shreg_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg -- universal shift register with multi-shift burst commands.
//   clk, rst        : clock, synchronous active-high reset
//   start           : command strobe (accepted only when idle)
//   mode            : 00 nop, 01 shift right, 10 shift left, 11 parallel load
//   shift_cnt       : shifts per burst command
//   d               : parallel load data
//   sin_l / sin_r   : serial input into q[WIDTH-1] (right shift) / q[0] (left shift)
//   q               : register contents
//   sout_r / sout_l : q[0] / q[WIDTH-1]
//   busy            : shift burst in progress
//   done            : one-cycle completion pulse
//   rot             : (only with SHREG_ROTATE_EN) rotate instead of serial fill
// Optional feature macro: SHREG_ROTATE_EN
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] shift_cnt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
`ifdef SHREG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dir_left_q, dir_left_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             fill_r, fill_l;
    mode_e            cmd;

    assign cmd = mode_e'(mode);

`ifdef SHREG_ROTATE_EN
    logic rot_q, rot_d;
    assign fill_r = rot_q ? q_q[0]       : sin_l;
    assign fill_l = rot_q ? q_q[WIDTH-1] : sin_r;
`else
    assign fill_r = sin_l;
    assign fill_l = sin_r;
`endif

    // Counter is loaded with N-1 so that zero marks the final shift edge.
    shreg_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (shift_cnt - CNT_W'(1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dir_left_d = dir_left_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
`ifdef SHREG_ROTATE_EN
        rot_d      = rot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (cmd)
                        MODE_LOAD: begin
                            q_d    = d;
                            done_d = 1'b1;
                        end
                        MODE_NOP: done_d = 1'b1;
                        default: begin
                            // A zero-length shift behaves like a nop.
                            if (shift_cnt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d    = ST_SHIFT;
                                busy_d     = 1'b1;
                                dir_left_d = (cmd == MODE_SHL);
                                cnt_load   = 1'b1;
`ifdef SHREG_ROTATE_EN
                                rot_d      = rot;
`endif
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                q_d = dir_left_q ? {q_q[WIDTH-2:0], fill_l}
                                 : {fill_r, q_q[WIDTH-1:1]};
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            q_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dir_left_q <= 1'b0;
`ifdef SHREG_ROTATE_EN
            rot_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dir_left_q <= dir_left_d;
`ifdef SHREG_ROTATE_EN
            rot_q      <= rot_d;
`endif
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg -- directed bench for univ_shift_reg (WIDTH=8).
// Expected post-edge state is queued before each edge and checked after it.
module tb_univ_shift_reg;
    import shreg_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] shift_cnt;
    logic [WIDTH-1:0] d;
    logic             sin_l, sin_r;
    logic [WIDTH-1:0] q;
    logic             sout_r, sout_l, busy, done;
`ifdef SHREG_ROTATE_EN
    logic             rot;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        string            tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .shift_cnt (shift_cnt),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
`ifdef SHREG_ROTATE_EN
        .rot       (rot),
`endif
        .q         (q),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .busy      (busy),
        .done      (done)
    );

    // Queue the expected result, clock once, then compare after the edge.
    task automatic cyc(input logic [WIDTH-1:0] eq, input logic eb, input logic ed,
                       input string tag);
        exp_t e;
        sb.push_back('{q: eq, busy: eb, done: ed, tag: tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (q === e.q) else begin
            failures++;
            $error("FAIL %s q got=%h exp=%h", e.tag, q, e.q);
        end
        checks++;
        assert (busy === e.busy) else begin
            failures++;
            $error("FAIL %s busy got=%b exp=%b", e.tag, busy, e.busy);
        end
        checks++;
        assert (done === e.done) else begin
            failures++;
            $error("FAIL %s done got=%b exp=%b", e.tag, done, e.done);
        end
        checks++;
        assert (sout_r === e.q[0] && sout_l === e.q[WIDTH-1]) else begin
            failures++;
            $error("FAIL %s sout got=%b%b exp=%b%b", e.tag, sout_l, sout_r,
                   e.q[WIDTH-1], e.q[0]);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] m;
        rst = 1'b1; start = 1'b0; mode = 2'b00; shift_cnt = '0; d = '0;
        sin_l = 1'b0; sin_r = 1'b0;
`ifdef SHREG_ROTATE_EN
        rot = 1'b0;
`endif
        #2;
        cyc(8'h00, 0, 0, "reset");
        rst = 1'b0;

        // Parallel load
        start = 1'b1; mode = 2'b11; d = 8'hA5;
        cyc(8'hA5, 0, 1, "load");
        start = 1'b0;
        cyc(8'hA5, 0, 0, "load_after");

        // Right shift x3 with sin_l=1
        start = 1'b1; mode = 2'b01; shift_cnt = 3; sin_l = 1'b1;
        cyc(8'hA5, 1, 0, "shr_accept");
        start = 1'b0;
        cyc(8'hD2, 1, 0, "shr_1");
        cyc(8'hE9, 1, 0, "shr_2");
        cyc(8'hF4, 0, 1, "shr_3_done");
        cyc(8'hF4, 0, 0, "shr_after");

        // Load 81, then start a left shift while done is high
        start = 1'b1; mode = 2'b11; d = 8'h81;
        cyc(8'h81, 0, 1, "load81");
        mode = 2'b10; shift_cnt = 2; sin_r = 1'b0;
        cyc(8'h81, 1, 0, "shl_accept_on_done");
        mode = 2'b11; d = 8'hFF; shift_cnt = 7;   // ignored while busy
        cyc(8'h02, 1, 0, "shl_1_ignore");
        cyc(8'h04, 0, 1, "shl_2_done");
        start = 1'b0;
        cyc(8'h04, 0, 0, "shl_after");

        // Burst longer than WIDTH: 10 left shifts filling ones
        start = 1'b1; mode = 2'b10; shift_cnt = 10; sin_r = 1'b1;
        cyc(8'h04, 1, 0, "long_accept");
        start = 1'b0;
        m = 8'h04;
        for (int i = 0; i < 10; i++) begin
            m = {m[WIDTH-2:0], 1'b1};
            cyc(m, (i < 9), (i == 9), "long_shift");
        end
        cyc(m, 0, 0, "long_after");

        // Zero-length shift and nop
        start = 1'b1; mode = 2'b01; shift_cnt = 0;
        cyc(m, 0, 1, "shr_n0");
        mode = 2'b00; shift_cnt = 3;
        cyc(m, 0, 1, "nop");
        start = 1'b0;
        cyc(m, 0, 0, "nop_after");

        // Right shift with per-edge varying serial input
        start = 1'b1; mode = 2'b01; shift_cnt = 4;
        cyc(m, 1, 0, "var_accept");
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin_l = 1'($urandom_range(0, 1));
            m = {sin_l, m[WIDTH-1:1]};
            cyc(m, (i < 3), (i == 3), "var_shift");
        end

        // Reset aborts a burst: no done afterwards
        start = 1'b1; mode = 2'b11; d = 8'hFF;
        cyc(8'hFF, 0, 1, "loadFF");
        mode = 2'b01; shift_cnt = 5; sin_l = 1'b0;
        cyc(8'hFF, 1, 0, "abort_accept");
        start = 1'b0;
        cyc(8'h7F, 1, 0, "abort_1");
        cyc(8'h3F, 1, 0, "abort_2");
        rst = 1'b1;
        cyc(8'h00, 0, 0, "abort_rst");
        rst = 1'b0;
        cyc(8'h00, 0, 0, "abort_no_done");
        cyc(8'h00, 0, 0, "abort_idle");

`ifdef SHREG_ROTATE_EN
        // Rotate right by one
        start = 1'b1; mode = 2'b11; d = 8'h81;
        cyc(8'h81, 0, 1, "rot_load");
        mode = 2'b01; shift_cnt = 1; rot = 1'b1; sin_l = 1'b0;
        cyc(8'h81, 1, 0, "rot_accept");
        start = 1'b0; rot = 1'b0;
        cyc(8'hC0, 0, 1, "rot_done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
